udp_rx_stream: RTL and testbench

//  GMII-side IPv4/UDP receive parser; parametrised successor of the single-port 32-bit UDP receiver.

---
 rtl/udp_rx_stream_if.sv | 22 ++
 rtl/udp_rx_stream.sv | 228 ++++++++++++++++++++++
 tb/tb_udp_rx_stream.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_rx_stream_if.sv
// GMII receive input plus packed payload stream output of the UDP receive parser.
// master = GMII source / payload sink side, slave = parser side.
interface udp_rx_stream_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [7:0]          datain;
  logic                e_rxdv;
  logic [DATA_W-1:0]   data_o;
  logic [DATA_W/8-1:0] data_o_keep;
  logic                data_o_valid;
  logic                data_o_last;

  modport master (
    output datain, e_rxdv,
    input  data_o, data_o_keep, data_o_valid, data_o_last
  );

  modport slave (
    input  datain, e_rxdv,
    output data_o, data_o_keep, data_o_valid, data_o_last
  );
endinterface

// File: rtl/udp_rx_stream.sv
// GMII IPv4/UDP receive parser: strips headers, filters MAC/IP/port, packs payload big-endian.
// Define UDP_RX_IPCSUM_EN to also drop frames whose IPv4 header checksum is wrong.
module udp_rx_stream #(
  parameter int unsigned DATA_W       = 32,
  parameter logic [47:0] BOARD_MAC    = 48'h000a3501fec0,
  parameter logic [31:0] BOARD_IP     = 32'hc0a80002,
  parameter logic [15:0] UDP_PORT     = 16'd0,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic           clk,
  input  logic           clr,
  udp_rx_stream_if.slave gmii,
  output logic           frame_done,
  output logic           frame_drop,
  output logic [47:0]    pc_mac,
  output logic [31:0]    pc_IP,
  output logic [15:0]    src_port,
  output logic [15:0]    rx_data_length
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NB - 1);

  typedef enum logic [3:0] {
    StIdle, StPre, StSfdWait, StEth, StIp, StUdp, StPayload, StDone, StDrop, StGap
  } state_e;

  state_e          state_q;
  logic [4:0]      cnt_q;
  logic [39:0]     hdr_q;
  logic [47:0]     hdr_next;
  logic [47:0]     mac_cand_q;
  logic [31:0]     ip_cand_q;
  logic [15:0]     port_cand_q;
  logic [15:0]     len_q;
  logic [15:0]     pay_cnt_q;
  logic [DATA_W-1:0] acc_q, word_d;
  logic [NB-1:0]   keep_acc_q, keep_d;
  logic [IdxW-1:0] idx_q;
  logic            mac_ok, hdr_fail, csum_bad, last_byte;

  // Last six bytes seen, newest in the LSBs; header fields are sliced from here.
  assign hdr_next  = {hdr_q, gmii.datain};
  assign mac_ok    = (hdr_next == BOARD_MAC) ||
                     (ACCEPT_BCAST && (hdr_next == 48'hffff_ffff_ffff));
  assign last_byte = (pay_cnt_q == len_q - 16'd1);

`ifdef UDP_RX_IPCSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    logic [16:0] sum;
    sum    = {1'b0, (cnt_q == 5'd1) ? 16'h0000 : csum_q} + {1'b0, hdr_next[15:0]};
    csum_d = sum[15:0] + {15'b0, sum[16]};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      csum_q <= 16'h0000;
    end else if (state_q == StIp && gmii.e_rxdv && cnt_q[0]) begin
      csum_q <= csum_d;
    end
  end

  assign csum_bad = (csum_d != 16'hffff);
`else
  assign csum_bad = 1'b0;
`endif

  always_comb begin
    hdr_fail = 1'b0;
    unique case (state_q)
      StEth: begin
        if (cnt_q == 5'd5)  hdr_fail = !mac_ok;
        if (cnt_q == 5'd13) hdr_fail = (hdr_next[15:0] != 16'h0800);
      end
      StIp: begin
        if (cnt_q == 5'd0)  hdr_fail = (gmii.datain != 8'h45);
        if (cnt_q == 5'd9)  hdr_fail = (gmii.datain != 8'd17);
        if (cnt_q == 5'd19) hdr_fail = (hdr_next[31:0] != BOARD_IP) || csum_bad;
      end
      StUdp: begin
        if (cnt_q == 5'd3) hdr_fail = (UDP_PORT != 16'd0) && (hdr_next[15:0] != UDP_PORT);
        if (cnt_q == 5'd5) hdr_fail = (hdr_next[15:0] < 16'd8);
      end
      default: hdr_fail = 1'b0;
    endcase
  end

  // Place the incoming byte at its big-endian slot; a new word starts from zero.
  always_comb begin
    word_d = (idx_q == '0) ? '0 : acc_q;
    keep_d = (idx_q == '0) ? '0 : keep_acc_q;
    for (int unsigned b = 0; b < NB; b++) begin
      if (idx_q == b[IdxW-1:0]) begin
        word_d[DATA_W-1-8*b -: 8] = gmii.datain;
        keep_d[NB-1-b]            = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      hdr_q             <= '0;
      mac_cand_q        <= '0;
      ip_cand_q         <= '0;
      port_cand_q       <= '0;
      len_q             <= '0;
      pay_cnt_q         <= '0;
      acc_q             <= '0;
      keep_acc_q        <= '0;
      idx_q             <= '0;
      gmii.data_o       <= '0;
      gmii.data_o_keep  <= '0;
      gmii.data_o_valid <= 1'b0;
      gmii.data_o_last  <= 1'b0;
      frame_done        <= 1'b0;
      frame_drop        <= 1'b0;
      pc_mac            <= '0;
      pc_IP             <= '0;
      src_port          <= '0;
      rx_data_length    <= '0;
    end else begin
      gmii.data_o_valid <= 1'b0;
      gmii.data_o_last  <= 1'b0;
      frame_done        <= 1'b0;
      frame_drop        <= 1'b0;
      hdr_q             <= hdr_next[39:0];
      cnt_q             <= cnt_q + 5'd1;

      unique case (state_q)
        StIdle: begin
          cnt_q <= 5'd1;
          // Joining mid-frame: wait for the line to go idle rather than hunt for 0x55.
          if (gmii.e_rxdv) state_q <= (gmii.datain == 8'h55) ? StPre : StGap;
        end
        StPre: begin
          if (!gmii.e_rxdv) begin
            state_q <= StIdle;
          end else if (gmii.datain == 8'h55) begin
            if (cnt_q == 5'd6) state_q <= StSfdWait;
          end else if (gmii.datain == 8'hd5) begin
            state_q <= StEth;
            cnt_q   <= '0;
          end else begin
            state_q <= StGap;
          end
        end
        StSfdWait: begin
          if (!gmii.e_rxdv) begin
            state_q <= StIdle;
          end else if (gmii.datain == 8'hd5) begin
            state_q <= StEth;
            cnt_q   <= '0;
          end else begin
            state_q <= StGap;
          end
        end
        StEth, StIp, StUdp: begin
          if (!gmii.e_rxdv || hdr_fail) begin
            state_q    <= StDrop;
            frame_drop <= 1'b1;
          end else begin
            if (state_q == StEth && cnt_q == 5'd11) mac_cand_q  <= hdr_next;
            if (state_q == StIp  && cnt_q == 5'd15) ip_cand_q   <= hdr_next[31:0];
            if (state_q == StUdp && cnt_q == 5'd1)  port_cand_q <= hdr_next[15:0];
            if (state_q == StUdp && cnt_q == 5'd5)  len_q       <= hdr_next[15:0] - 16'd8;
            if (state_q == StEth && cnt_q == 5'd13) begin
              state_q <= StIp;
              cnt_q   <= '0;
            end
            if (state_q == StIp && cnt_q == 5'd19) begin
              state_q <= StUdp;
              cnt_q   <= '0;
            end
            if (state_q == StUdp && cnt_q == 5'd7) begin
              pay_cnt_q <= '0;
              idx_q     <= '0;
              if (len_q == 16'd0) begin
                state_q        <= StDone;
                frame_done     <= 1'b1;
                pc_mac         <= mac_cand_q;
                pc_IP          <= ip_cand_q;
                src_port       <= port_cand_q;
                rx_data_length <= len_q;
              end else begin
                state_q <= StPayload;
              end
            end
          end
        end
        StPayload: begin
          if (!gmii.e_rxdv) begin
            state_q    <= StDrop;
            frame_drop <= 1'b1;
          end else begin
            acc_q      <= word_d;
            keep_acc_q <= keep_d;
            pay_cnt_q  <= pay_cnt_q + 16'd1;
            idx_q      <= idx_q + 1'b1;
            if (last_byte || idx_q == LastIdx) begin
              gmii.data_o       <= word_d;
              gmii.data_o_keep  <= keep_d;
              gmii.data_o_valid <= 1'b1;
              idx_q             <= '0;
            end
            if (last_byte) begin
              gmii.data_o_last <= 1'b1;
              state_q          <= StDone;
              frame_done       <= 1'b1;
              pc_mac           <= mac_cand_q;
              pc_IP            <= ip_cand_q;
              src_port         <= port_cand_q;
              rx_data_length   <= len_q;
            end
          end
        end
        StDone, StDrop: state_q <= StGap;
        StGap: if (!gmii.e_rxdv) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_stream.sv
// Directed bench for udp_rx_stream: valid frames, partial words, filters, truncation, reset.
module tb_udp_rx_stream;

  localparam logic [47:0] BoardMac = 48'h000a3501fec0;
  localparam logic [47:0] SrcMac   = 48'h665544332211;
  localparam logic [31:0] SrcIp    = 32'hc0a80003;
  localparam logic [31:0] DstIp    = 32'hc0a80002;
  localparam int          HdrLen   = 50;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  udp_rx_stream_if #(.DATA_W(32)) g ();
  udp_rx_stream_if #(.DATA_W(32)) gp ();
  assign gp.datain = g.datain;
  assign gp.e_rxdv = g.e_rxdv;

  logic        frame_done, frame_drop, p_frame_done, p_frame_drop;
  logic [47:0] pc_mac, p_pc_mac;
  logic [31:0] pc_ip, p_pc_ip;
  logic [15:0] src_port, rx_len, p_src_port, p_rx_len;

  udp_rx_stream dut (
    .clk(clk), .clr(clr), .gmii(g.slave), .frame_done(frame_done), .frame_drop(frame_drop),
    .pc_mac(pc_mac), .pc_IP(pc_ip), .src_port(src_port), .rx_data_length(rx_len)
  );

  udp_rx_stream #(.UDP_PORT(16'd5000)) dut_p (
    .clk(clk), .clr(clr), .gmii(gp.slave), .frame_done(p_frame_done),
    .frame_drop(p_frame_drop), .pc_mac(p_pc_mac), .pc_IP(p_pc_ip), .src_port(p_src_port),
    .rx_data_length(p_rx_len)
  );

  int n_vec = 0;
  int n_err = 0;
  int ncyc = 0, n_done = 0, n_drop = 0, p_done = 0, p_drop = 0;
  int lp_ncyc = 0;
  logic [31:0] w_data[$];
  logic [3:0]  w_keep[$];
  logic        w_last[$];
  int          w_cyc[$];
  logic [7:0]  fr[$];
  logic [7:0]  pl[$];

  always @(negedge clk) begin
    ncyc++;
    if (g.data_o_valid) begin
      w_data.push_back(g.data_o);
      w_keep.push_back(g.data_o_keep);
      w_last.push_back(g.data_o_last);
      w_cyc.push_back(ncyc);
    end
    if (frame_done)   n_done++;
    if (frame_drop)   n_drop++;
    if (p_frame_done) p_done++;
    if (p_frame_drop) p_drop++;
  end

  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] dport);
    logic [7:0]  ip[20];
    logic [15:0] tl, ul;
    logic [31:0] sum;
    tl = 16'(28 + pl.size());
    ul = 16'(8 + pl.size());
    ip = '{8'h45, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
           8'h00, 8'h00, SrcIp[31:24], SrcIp[23:16], SrcIp[15:8], SrcIp[7:0],
           DstIp[31:24], DstIp[23:16], DstIp[15:8], DstIp[7:0]};
    sum = 32'h0;
    for (int i = 0; i < 20; i += 2) sum += {16'h0, ip[i], ip[i+1]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    ip[10] = ~sum[15:8];
    ip[11] = ~sum[7:0];
    fr.delete();
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hd5);
    for (int i = 5; i >= 0; i--) fr.push_back(dmac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) fr.push_back(SrcMac[8*i +: 8]);
    fr.push_back(8'h08);
    fr.push_back(8'h00);
    for (int i = 0; i < 20; i++) fr.push_back(ip[i]);
    fr.push_back(8'h1f);
    fr.push_back(8'h90);
    fr.push_back(dport[15:8]);
    fr.push_back(dport[7:0]);
    fr.push_back(ul[15:8]);
    fr.push_back(ul[7:0]);
    fr.push_back(8'h00);
    fr.push_back(8'h00);
    for (int i = 0; i < pl.size(); i++) fr.push_back(pl[i]);
    fr.push_back(8'hde); fr.push_back(8'had); fr.push_back(8'hbe); fr.push_back(8'hef);
  endtask

  // Drive the first n bytes of fr, then an idle gap.
  task automatic send(input int n);
    for (int i = 0; i < fr.size() && i < n; i++) begin
      @(posedge clk); #1;
      g.e_rxdv = 1'b1;
      g.datain = fr[i];
      if (i == HdrLen + pl.size() - 1) lp_ncyc = ncyc;
    end
    @(posedge clk); #1;
    g.e_rxdv = 1'b0;
    g.datain = 8'h00;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    g.e_rxdv = 1'b0;
    g.datain = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({g.data_o, g.data_o_keep, g.data_o_valid, g.data_o_last} !== 38'h0) begin
      n_err++;
      $display("FAIL reset_stream: got %h want 0",
               {g.data_o, g.data_o_keep, g.data_o_valid, g.data_o_last});
    end
    n_vec++;
    if ({frame_done, frame_drop} !== 2'b00) begin
      n_err++; $display("FAIL reset_pulses: got %b want 00", {frame_done, frame_drop});
    end
    n_vec++;
    if ({pc_mac, pc_ip, src_port, rx_len} !== 112'h0) begin
      n_err++; $display("FAIL reset_fields: got %h want 0", {pc_mac, pc_ip, src_port, rx_len});
    end
    clr = 1'b0;
  endtask

  task automatic test_valid_frame;
    int b, d0, p0;
    b = w_data.size(); d0 = n_done; p0 = p_done;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build_frame(BoardMac, 16'd5000);
    send(fr.size());
    n_vec++;
    if (w_data.size() - b !== 2) begin
      n_err++; $display("FAIL t1_word_count: got %0d want 2", w_data.size() - b);
    end else begin
      n_vec++;
      if ({w_data[b], w_keep[b], w_last[b]} !== {32'h01020304, 4'hf, 1'b0}) begin
        n_err++; $display("FAIL t1_word0: got %h/%h/%b want 01020304/f/0",
                          w_data[b], w_keep[b], w_last[b]);
      end
      n_vec++;
      if ({w_data[b+1], w_keep[b+1], w_last[b+1]} !== {32'h05060708, 4'hf, 1'b1}) begin
        n_err++; $display("FAIL t1_word1: got %h/%h/%b want 05060708/f/1",
                          w_data[b+1], w_keep[b+1], w_last[b+1]);
      end
      n_vec++;
      if (w_cyc[b+1] !== lp_ncyc + 2) begin
        n_err++; $display("FAIL t1_latency: got cycle %0d want %0d", w_cyc[b+1], lp_ncyc + 2);
      end
    end
    n_vec++;
    if ({n_done - d0, p_done - p0} !== {32'd1, 32'd1}) begin
      n_err++; $display("FAIL t1_done: got %0d/%0d want 1/1", n_done - d0, p_done - p0);
    end
    n_vec++;
    if ({pc_mac, pc_ip, src_port, rx_len} !== {SrcMac, SrcIp, 16'h1f90, 16'd8}) begin
      n_err++; $display("FAIL t1_fields: got %h/%h/%h/%0d want 665544332211/c0a80003/1f90/8",
                        pc_mac, pc_ip, src_port, rx_len);
    end
  endtask

  task automatic test_partial_word;
    int b;
    b = w_data.size();
    pl = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee};
    build_frame(BoardMac, 16'd5000);
    send(fr.size());
    n_vec++;
    if (w_data.size() - b !== 2) begin
      n_err++; $display("FAIL t2_word_count: got %0d want 2", w_data.size() - b);
    end else begin
      n_vec++;
      if ({w_data[b], w_keep[b], w_last[b]} !== {32'haabbccdd, 4'hf, 1'b0}) begin
        n_err++; $display("FAIL t2_word0: got %h/%h/%b want aabbccdd/f/0",
                          w_data[b], w_keep[b], w_last[b]);
      end
      n_vec++;
      if ({w_data[b+1], w_keep[b+1], w_last[b+1]} !== {32'hee000000, 4'h8, 1'b1}) begin
        n_err++; $display("FAIL t2_word1: got %h/%h/%b want ee000000/8/1",
                          w_data[b+1], w_keep[b+1], w_last[b+1]);
      end
    end
    n_vec++;
    if (rx_len !== 16'd5) begin
      n_err++; $display("FAIL t2_length: got %0d want 5", rx_len);
    end
  endtask

  task automatic test_filter;
    int b, d0, r0, pd0, pr0;
    b = w_data.size(); d0 = n_done; r0 = n_drop;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_frame(48'h001122334455, 16'd5000);
    send(fr.size());
    n_vec++;
    if ({w_data.size() - b, n_done - d0, n_drop - r0} !== {32'd0, 32'd0, 32'd1}) begin
      n_err++; $display("FAIL t3_mac_filter: got words/done/drop %0d/%0d/%0d want 0/0/1",
                        w_data.size() - b, n_done - d0, n_drop - r0);
    end
    n_vec++;
    if ({pc_mac, src_port, rx_len} !== {SrcMac, 16'h1f90, 16'd5}) begin
      n_err++; $display("FAIL t3_hold: got %h/%h/%0d want 665544332211/1f90/5",
                        pc_mac, src_port, rx_len);
    end
    // Port 1234: the any-port instance accepts, the port-5000 instance drops.
    b = w_data.size(); d0 = n_done; pd0 = p_done; pr0 = p_drop;
    build_frame(BoardMac, 16'd1234);
    send(fr.size());
    n_vec++;
    if ({p_done - pd0, p_drop - pr0} !== {32'd0, 32'd1}) begin
      n_err++; $display("FAIL t3_port_filter: got done/drop %0d/%0d want 0/1",
                        p_done - pd0, p_drop - pr0);
    end
    n_vec++;
    if ({n_done - d0, p_rx_len} !== {32'd1, 16'd5}) begin
      n_err++; $display("FAIL t3_any_port: got done %0d len_p %0d want 1/5", n_done - d0, p_rx_len);
    end
    n_vec++;
    if (w_data.size() - b !== 1) begin
      n_err++; $display("FAIL t3_exact_word_count: got %0d want 1", w_data.size() - b);
    end else begin
      n_vec++;
      if ({w_data[b], w_keep[b], w_last[b]} !== {32'h11223344, 4'hf, 1'b1}) begin
        n_err++; $display("FAIL t3_exact_word: got %h/%h/%b want 11223344/f/1",
                          w_data[b], w_keep[b], w_last[b]);
      end
    end
    d0 = n_done;
    build_frame(48'hffffffffffff, 16'd5000);
    send(fr.size());
    n_vec++;
    if (n_done - d0 !== 1) begin
      n_err++; $display("FAIL t3_broadcast: got done %0d want 1", n_done - d0);
    end
  endtask

  task automatic test_truncated;
    int b, d0, r0, lastc;
    b = w_data.size(); d0 = n_done; r0 = n_drop;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build_frame(BoardMac, 16'd5000);
    send(HdrLen + 3);
    n_vec++;
    if ({w_data.size() - b, n_done - d0, n_drop - r0} !== {32'd0, 32'd0, 32'd1}) begin
      n_err++; $display("FAIL t4_truncated: got words/done/drop %0d/%0d/%0d want 0/0/1",
                        w_data.size() - b, n_done - d0, n_drop - r0);
    end
    b = w_data.size(); d0 = n_done;
    pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    build_frame(BoardMac, 16'd5000);
    send(fr.size());
    lastc = 0;
    for (int i = b; i < w_data.size(); i++) if (w_last[i]) lastc++;
    n_vec++;
    if ({w_data.size() - b, n_done - d0, lastc} !== {32'd2, 32'd1, 32'd1}) begin
      n_err++; $display("FAIL t4_recover: got words/done/last %0d/%0d/%0d want 2/1/1",
                        w_data.size() - b, n_done - d0, lastc);
    end else begin
      n_vec++;
      if ({w_data[b], w_data[b+1]} !== 64'h10111213_14151617) begin
        n_err++; $display("FAIL t4_recover_data: got %h %h want 10111213 14151617",
                          w_data[b], w_data[b+1]);
      end
    end
  endtask

  task automatic test_zero_payload;
    int b, d0;
    b = w_data.size(); d0 = n_done;
    pl.delete();
    build_frame(BoardMac, 16'd5000);
    send(fr.size());
    n_vec++;
    if ({w_data.size() - b, n_done - d0, rx_len} !== {32'd0, 32'd1, 16'd0}) begin
      n_err++; $display("FAIL t_zero_len: got words/done/len %0d/%0d/%0d want 0/1/0",
                        w_data.size() - b, n_done - d0, rx_len);
    end
  endtask

  task automatic test_clr;
    int d0, r0;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build_frame(BoardMac, 16'd5000);
    for (int i = 0; i < HdrLen + 5; i++) begin
      @(posedge clk); #1;
      g.e_rxdv = 1'b1;
      g.datain = fr[i];
    end
    @(posedge clk); #1;
    d0 = n_done; r0 = n_drop;
    clr = 1'b1;
    g.e_rxdv = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({g.data_o, g.data_o_keep, g.data_o_valid, g.data_o_last, frame_done, frame_drop,
         pc_mac, pc_ip, src_port, rx_len} !== 152'h0) begin
      n_err++; $display("FAIL t5_clr_outputs: got %h/%h/%h/%0d data %h want all 0",
                        pc_mac, pc_ip, src_port, rx_len, g.data_o);
    end
    clr = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_vec++;
    if ({n_done - d0, n_drop - r0} !== {32'd0, 32'd0}) begin
      n_err++; $display("FAIL t5_clr_no_pulse: got done/drop %0d/%0d want 0/0",
                        n_done - d0, n_drop - r0);
    end
    d0 = n_done;
    send(fr.size());
    n_vec++;
    if ({n_done - d0, pc_mac, rx_len} !== {32'd1, SrcMac, 16'd8}) begin
      n_err++; $display("FAIL t5_after_clr: got done %0d mac %h len %0d want 1/665544332211/8",
                        n_done - d0, pc_mac, rx_len);
    end
  endtask

  task automatic test_ipcsum;
    int d0, r0;
    d0 = n_done; r0 = n_drop;
    pl = '{8'h5a, 8'h5b};
    build_frame(BoardMac, 16'd5000);
    fr[8 + 14 + 10] = fr[8 + 14 + 10] ^ 8'h01;
    send(fr.size());
    n_vec++;
`ifdef UDP_RX_IPCSUM_EN
    if ({n_done - d0, n_drop - r0} !== {32'd0, 32'd1}) begin
      n_err++; $display("FAIL t6_csum_drop: got done/drop %0d/%0d want 0/1",
                        n_done - d0, n_drop - r0);
    end
`else
    if ({n_done - d0, n_drop - r0} !== {32'd1, 32'd0}) begin
      n_err++; $display("FAIL t6_csum_ignored: got done/drop %0d/%0d want 1/0",
                        n_done - d0, n_drop - r0);
    end
`endif
  endtask

  initial begin
    clr = 1'b1;
    g.e_rxdv = 1'b0;
    g.datain = 8'h00;
    test_reset();
    test_valid_frame();
    test_partial_word();
    test_filter();
    test_truncated();
    test_zero_payload();
    test_clr();
    test_ipcsum();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
